// File: rtl/otter_mem_pkg.sv
// otter_mem_pkg: shared types, constants and lane/extension helpers for the OTTER memory responder
package otter_mem_pkg;
  typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10, ILLEGAL = 2'b11} mem_size_t;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} port_state_t;
  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h1100_0000;
  function automatic logic [3:0] lane_mask(input mem_size_t s, input logic [1:0] off);
    return s == BYTE ? 4'b0001 << off : s == HALF ? (off[1] ? 4'b1100 : 4'b0011) : s == WORD ? 4'b1111 : 4'b0000;
  endfunction
  function automatic logic [31:0] store_data(input mem_size_t s, input logic [31:0] d);
    return s == BYTE ? {4{d[7:0]}} : s == HALF ? {2{d[15:0]}} : d;
  endfunction
  function automatic logic [31:0] load_ext(input logic [31:0] w, input mem_size_t s, input logic [1:0] off, input logic u);
    logic [7:0] b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    return s == BYTE ? {{24{~u & b[7]}}, b} : s == HALF ? {{16{~u & h[15]}}, h} : w;
  endfunction
  function automatic logic misaligned(input mem_size_t s, input logic [1:0] off);
    return s == ILLEGAL || (s == HALF && off[0]) || (s == WORD && off != 2'b00);
  endfunction
endpackage

// File: rtl/otter_mem_port_fsm.sv
// otter_mem_port_fsm: per-port IDLE/WAIT/RESP sequencer with wait-state counter
module otter_mem_port_fsm import otter_mem_pkg::*; #(
  parameter int WAIT_STATES = 1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic req,
  output logic idle,
  output logic accept,
  output logic enter,
  output logic valid
);
  port_state_t st, nx;
  logic [3:0] cnt;
  // state register and wait counter, loaded on acceptance
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      st <= IDLE;
      cnt <= '0;
    end else begin
      st <= nx;
      cnt <= accept ? 4'(WAIT_STATES) : st == WAIT ? cnt - 4'd1 : cnt;
    end
  // next state; enter marks the edge on which the access commits
  always_comb begin
    idle = st == IDLE;
    accept = idle && req;
    valid = st == RESP;
    nx = accept ? (WAIT_STATES == 0 ? RESP : WAIT) : st == WAIT ? (cnt == 4'd1 ? RESP : WAIT) : st == RESP ? IDLE : st;
    enter = nx == RESP && !valid;
  end
endmodule

// File: rtl/otter_mem_responder.sv
// otter_mem_responder: OTTER fetch/data memory with MMIO window; define OTTER_MEM_PERF_EN for port-2 access counters
module otter_mem_responder import otter_mem_pkg::*; #(
  parameter int ADDR_WIDTH = 14,
  parameter int WAIT_STATES = 1,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        MEM_RDEN1,
  input  logic [31:0] MEM_ADDR1,
  output logic [31:0] MEM_DOUT1,
  output logic        MEM_VALID1,
  output logic        MEM_ERR1,
  input  logic        MEM_RDEN2,
  input  logic        MEM_WE2,
  input  logic [31:0] MEM_ADDR2,
  input  logic [31:0] MEM_DIN2,
  input  logic [1:0]  MEM_SIZE,
  input  logic        MEM_SIGN,
  output logic [31:0] MEM_DOUT2,
  output logic        MEM_VALID2,
  output logic        MEM_ERR2,
  input  logic [31:0] IO_IN,
  output logic [31:0] IO_ADDR,
  output logic [31:0] IO_OUT,
  output logic        IO_WR
`ifdef OTTER_MEM_PERF_EN
  ,
  output logic [31:0] PERF_RD_CNT,
  output logic [31:0] PERF_WR_CNT
`endif
);
  logic [31:0] mem [2**ADDR_WIDTH];
  logic acc1, ent1, idle1, acc2, ent2, idle2;
  logic [31:0] a1_q, a2_q, din_q, ea1, ea2, ed2, wdat;
  mem_size_t sz_q, esz;
  logic sg_q, we_q, esg, ewe, err1, err2, mmio2, err1_q, err2_q;
  logic [ADDR_WIDTH-1:0] ix1, ix2;
  logic [3:0] be;
  otter_mem_port_fsm #(.WAIT_STATES(WAIT_STATES)) u_p1 (
    .CLK(CLK), .RST_N(RST_N), .req(MEM_RDEN1), .idle(idle1), .accept(acc1), .enter(ent1), .valid(MEM_VALID1)
  );
  otter_mem_port_fsm #(.WAIT_STATES(WAIT_STATES)) u_p2 (
    .CLK(CLK), .RST_N(RST_N), .req(MEM_RDEN2 | MEM_WE2), .idle(idle2), .accept(acc2), .enter(ent2), .valid(MEM_VALID2)
  );
  // live inputs while idle so zero wait states commit on the acceptance edge
  always_comb begin
    ea1 = idle1 ? MEM_ADDR1 : a1_q;
    ea2 = idle2 ? MEM_ADDR2 : a2_q;
    ed2 = idle2 ? MEM_DIN2 : din_q;
    esz = idle2 ? mem_size_t'(MEM_SIZE) : sz_q;
    esg = idle2 ? MEM_SIGN : sg_q;
    ewe = idle2 ? MEM_WE2 : we_q;
    ix1 = ea1[ADDR_WIDTH+1:2];
    ix2 = ea2[ADDR_WIDTH+1:2];
    err1 = ea1[1:0] != 2'b00 || ea1 >= MMIO_BASE;
    err2 = misaligned(esz, ea2[1:0]);
    mmio2 = ea2 >= MMIO_BASE;
    wdat = store_data(esz, ed2);
    be = (ent2 && ewe && !err2 && !mmio2 && RST_N) ? lane_mask(esz, ea2[1:0]) : 4'b0000;
    MEM_ERR1 = err1_q & MEM_VALID1;
    MEM_ERR2 = err2_q & MEM_VALID2;
  end
  // request capture on acceptance
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      a1_q <= '0;
      a2_q <= '0;
      din_q <= '0;
      sz_q <= BYTE;
      sg_q <= 1'b0;
      we_q <= 1'b0;
    end else begin
      if (acc1) a1_q <= MEM_ADDR1;
      if (acc2) begin
        a2_q <= MEM_ADDR2;
        din_q <= MEM_DIN2;
        sz_q <= mem_size_t'(MEM_SIZE);
        sg_q <= MEM_SIGN;
        we_q <= MEM_WE2;
      end
    end
  // byte-lane store into the backing array
  always_ff @(posedge CLK)
    for (int i = 0; i < 4; i++)
      if (be[i]) mem[ix2][8*i +: 8] <= wdat[8*i +: 8];
  // response data, faults and MMIO bus; array reads see pre-store contents
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      MEM_DOUT1 <= '0;
      MEM_DOUT2 <= '0;
      err1_q <= 1'b0;
      err2_q <= 1'b0;
      IO_ADDR <= '0;
      IO_OUT <= '0;
      IO_WR <= 1'b0;
    end else begin
      if (ent1) begin
        MEM_DOUT1 <= err1 ? '0 : mem[ix1];
        err1_q <= err1;
      end
      if (ent2) begin
        err2_q <= err2;
        if (err2) MEM_DOUT2 <= '0;
        else if (!ewe) MEM_DOUT2 <= load_ext(mmio2 ? IO_IN : mem[ix2], esz, ea2[1:0], esg);
        if (mmio2) IO_ADDR <= ea2;
        if (mmio2 && ewe && !err2) IO_OUT <= ed2;
      end
      IO_WR <= ent2 && mmio2 && ewe && !err2;
    end
`ifdef OTTER_MEM_PERF_EN
  // saturating counts of accepted port-2 loads and stores
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      PERF_RD_CNT <= '0;
      PERF_WR_CNT <= '0;
    end else begin
      if (acc2 && !MEM_WE2 && PERF_RD_CNT != '1) PERF_RD_CNT <= PERF_RD_CNT + 32'd1;
      if (acc2 && MEM_WE2 && PERF_WR_CNT != '1) PERF_WR_CNT <= PERF_WR_CNT + 32'd1;
    end
`endif
endmodule

// File: tb/tb_otter_mem_responder.sv
// tb_otter_mem_responder: directed table-driven bench for otter_mem_responder
module tb_otter_mem_responder;
  logic CLK = 0, RST_N = 1;
  logic MEM_RDEN1 = 0, MEM_RDEN2 = 0, MEM_WE2 = 0, MEM_SIGN = 0;
  logic [31:0] MEM_ADDR1 = 0, MEM_ADDR2 = 0, MEM_DIN2 = 0, IO_IN = 0;
  logic [1:0] MEM_SIZE = 0;
  logic [31:0] MEM_DOUT1, MEM_DOUT2, IO_ADDR, IO_OUT;
  logic MEM_VALID1, MEM_ERR1, MEM_VALID2, MEM_ERR2, IO_WR;
`ifdef OTTER_MEM_PERF_EN
  logic [31:0] PERF_RD_CNT, PERF_WR_CNT;
`endif
  int total = 0, bad = 0;
  otter_mem_responder #(.WAIT_STATES(1)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .MEM_RDEN1(MEM_RDEN1), .MEM_ADDR1(MEM_ADDR1), .MEM_DOUT1(MEM_DOUT1), .MEM_VALID1(MEM_VALID1), .MEM_ERR1(MEM_ERR1),
    .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2), .MEM_SIZE(MEM_SIZE),
    .MEM_SIGN(MEM_SIGN), .MEM_DOUT2(MEM_DOUT2), .MEM_VALID2(MEM_VALID2), .MEM_ERR2(MEM_ERR2),
    .IO_IN(IO_IN), .IO_ADDR(IO_ADDR), .IO_OUT(IO_OUT), .IO_WR(IO_WR)
`ifdef OTTER_MEM_PERF_EN
    , .PERF_RD_CNT(PERF_RD_CNT), .PERF_WR_CNT(PERF_WR_CNT)
`endif
  );
  always #5 CLK = ~CLK;
  typedef struct {
    logic we, rd;
    logic [31:0] addr, din;
    logic [1:0] sz;
    logic sg;
    logic [31:0] io, dout;
    logic err, cd;
  } vec_t;
  localparam int NV = 19;
  vec_t tbl [NV];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  task automatic chk_zero(input string n);
    chk({n, " dout1"}, MEM_DOUT1, 0);
    chk({n, " valid1"}, {31'd0, MEM_VALID1}, 0);
    chk({n, " err1"}, {31'd0, MEM_ERR1}, 0);
    chk({n, " dout2"}, MEM_DOUT2, 0);
    chk({n, " valid2"}, {31'd0, MEM_VALID2}, 0);
    chk({n, " err2"}, {31'd0, MEM_ERR2}, 0);
    chk({n, " io_addr"}, IO_ADDR, 0);
    chk({n, " io_out"}, IO_OUT, 0);
    chk({n, " io_wr"}, {31'd0, IO_WR}, 0);
  endtask
  task automatic p2(input logic we, input logic rd, input logic [31:0] addr, input logic [31:0] din,
                    input logic [1:0] sz, input logic sg, input logic [31:0] io);
    int lat;
    MEM_WE2 = we; MEM_RDEN2 = rd; MEM_ADDR2 = addr; MEM_DIN2 = din; MEM_SIZE = sz; MEM_SIGN = sg; IO_IN = io;
    @(negedge CLK);
    MEM_WE2 = 0; MEM_RDEN2 = 0; MEM_ADDR2 = ~addr; MEM_DIN2 = ~din; MEM_SIZE = ~sz; MEM_SIGN = ~sg;
    lat = 1;
    while (!MEM_VALID2 && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    chk($sformatf("lat2 @%h", addr), lat, 2);
  endtask
  task automatic p1(input logic [31:0] addr);
    int lat;
    MEM_RDEN1 = 1; MEM_ADDR1 = addr;
    @(negedge CLK);
    MEM_RDEN1 = 0; MEM_ADDR1 = ~addr;
    lat = 1;
    while (!MEM_VALID1 && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    chk($sformatf("lat1 @%h", addr), lat, 2);
  endtask
  task automatic fetch_chk(input logic [31:0] addr, input logic [31:0] d, input logic e);
    p1(addr);
    chk($sformatf("fetch %h dout", addr), MEM_DOUT1, d);
    chk($sformatf("fetch %h err", addr), {31'd0, MEM_ERR1}, {31'd0, e});
    @(negedge CLK);
    chk("fetch pulse", {31'd0, MEM_VALID1}, 0);
  endtask
  initial begin
    tbl[0]  = '{1, 0, 32'h100, 32'hDEADBEEF, 2'b10, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 32'h100, 0, 2'b10, 0, 0, 32'hDEADBEEF, 0, 1};
    tbl[2]  = '{0, 1, 32'h103, 0, 2'b00, 0, 0, 32'hFFFFFFDE, 0, 1};
    tbl[3]  = '{0, 1, 32'h103, 0, 2'b00, 1, 0, 32'h000000DE, 0, 1};
    tbl[4]  = '{0, 1, 32'h102, 0, 2'b01, 0, 0, 32'hFFFFDEAD, 0, 1};
    tbl[5]  = '{1, 0, 32'h101, 32'h1234, 2'b01, 0, 0, 0, 1, 1};
    tbl[6]  = '{0, 1, 32'h100, 0, 2'b10, 0, 0, 32'hDEADBEEF, 0, 1};
    tbl[7]  = '{0, 1, 32'h100, 0, 2'b01, 1, 0, 32'h0000BEEF, 0, 1};
    tbl[8]  = '{1, 0, 32'h101, 32'h77, 2'b00, 0, 0, 0, 0, 0};
    tbl[9]  = '{0, 1, 32'h100, 0, 2'b10, 0, 0, 32'hDEAD77EF, 0, 1};
    tbl[10] = '{0, 1, 32'h100, 0, 2'b11, 0, 0, 0, 1, 1};
    tbl[11] = '{1, 1, 32'h104, 32'hCAFEF00D, 2'b10, 0, 0, 0, 0, 0};
    tbl[12] = '{0, 1, 32'h104, 0, 2'b10, 0, 0, 32'hCAFEF00D, 0, 1};
    tbl[13] = '{1, 0, 32'h106, 32'hAAAA1234, 2'b01, 0, 0, 0, 0, 0};
    tbl[14] = '{0, 1, 32'h10104, 0, 2'b10, 0, 0, 32'h1234F00D, 0, 1};
    tbl[15] = '{0, 1, 32'h102, 0, 2'b10, 0, 0, 0, 1, 1};
    tbl[16] = '{0, 1, 32'h11000004, 0, 2'b00, 0, 32'h80, 32'hFFFFFF80, 0, 1};
    tbl[17] = '{0, 1, 32'h11000006, 0, 2'b01, 1, 32'h80001234, 32'h00008000, 0, 1};
    tbl[18] = '{0, 1, 32'h106, 0, 2'b00, 0, 0, 32'h00000034, 0, 1};
    #1 RST_N = 0;
    #10 chk_zero("reset");
    @(negedge CLK);
    RST_N = 1;
    @(negedge CLK);
    p2(1, 0, 32'h200, 32'h0, 2'b10, 0, 0);
    @(negedge CLK);
    p2(1, 0, 32'h300, 32'h11111111, 2'b10, 0, 0);
    @(negedge CLK);
    p2(1, 0, 32'h4, 32'h0BADF00D, 2'b10, 0, 0);
    @(negedge CLK);
    for (int i = 0; i < NV; i++) begin
      p2(tbl[i].we, tbl[i].rd, tbl[i].addr, tbl[i].din, tbl[i].sz, tbl[i].sg, tbl[i].io);
      chk($sformatf("v%0d err", i), {31'd0, MEM_ERR2}, {31'd0, tbl[i].err});
      if (tbl[i].cd) chk($sformatf("v%0d dout", i), MEM_DOUT2, tbl[i].dout);
      @(negedge CLK);
      chk($sformatf("v%0d pulse", i), {31'd0, MEM_VALID2}, 0);
    end
    fetch_chk(32'h100, 32'hDEAD77EF, 0);
    fetch_chk(32'h102, 32'h0, 1);
    fetch_chk(32'h11000000, 32'h0, 1);
    fetch_chk(32'h104, 32'h1234F00D, 0);
    p2(1, 0, 32'h11000004, 32'h5A, 2'b10, 0, 0);
    chk("mmio wr", {31'd0, IO_WR}, 1);
    chk("mmio addr", IO_ADDR, 32'h11000004);
    chk("mmio out", IO_OUT, 32'h5A);
    chk("mmio err", {31'd0, MEM_ERR2}, 0);
    @(negedge CLK);
    chk("mmio wr pulse", {31'd0, IO_WR}, 0);
    p2(0, 1, 32'h4, 0, 2'b10, 0, 0);
    chk("mmio array untouched", MEM_DOUT2, 32'h0BADF00D);
    @(negedge CLK);
    MEM_WE2 = 1; MEM_ADDR2 = 32'h200; MEM_DIN2 = 32'h12345678; MEM_SIZE = 2'b10;
    MEM_RDEN1 = 1; MEM_ADDR1 = 32'h200;
    @(negedge CLK);
    MEM_WE2 = 0; MEM_RDEN1 = 0;
    for (int n = 0; n < 20 && !MEM_VALID1; n++) @(negedge CLK);
    chk("same edge valid1", {31'd0, MEM_VALID1}, 1);
    chk("same edge valid2", {31'd0, MEM_VALID2}, 1);
    chk("same edge old data", MEM_DOUT1, 32'h0);
    @(negedge CLK);
    fetch_chk(32'h200, 32'h12345678, 0);
    p2(0, 1, 32'h300, 0, 2'b10, 0, 0);
    chk("pre-reset load", MEM_DOUT2, 32'h11111111);
    @(negedge CLK);
    MEM_WE2 = 1; MEM_ADDR2 = 32'h300; MEM_DIN2 = 32'hAA; MEM_SIZE = 2'b00;
    @(negedge CLK);
    MEM_WE2 = 0;
    #1 RST_N = 0;
    #1 chk_zero("async reset");
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1;
`ifdef OTTER_MEM_PERF_EN
    chk("perf wr reset", PERF_WR_CNT, 0);
    chk("perf rd reset", PERF_RD_CNT, 0);
`endif
    @(negedge CLK);
    p2(0, 1, 32'h300, 0, 2'b10, 0, 0);
    chk("dropped store", MEM_DOUT2, 32'h11111111);
`ifdef OTTER_MEM_PERF_EN
    chk("perf rd one", PERF_RD_CNT, 1);
`endif
    @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/otter_mem_responder.md
Name: otter_mem_responder

Overview:
Memory-side responder for the OTTER MCU. It serves the control unit's two memory strobes: read port 1 for instruction fetch, and read/write port 2 for loads and stores. It owns the backing word array, byte-lane steering, load sign/zero extension, alignment checking and the MMIO window. Responses arrive after a programmable number of wait states, signalled by one-cycle valid pulses the control FSM can stall on.

Parameters:
ADDR_WIDTH, 14, word-address bits of backing array (2^14 words = 64 KiB)
WAIT_STATES, 1, idle cycles between request acceptance and response (0..15)
MMIO_BASE, 32'h1100_0000, byte addresses >= this route to IO bus

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
MEM_RDEN1  in  1  fetch request strobe
MEM_ADDR1  in  32  fetch byte address
MEM_DOUT1  out  32  fetched instruction
MEM_VALID1  out  1  one-cycle fetch response pulse
MEM_ERR1  out  1  fetch fault, qualified by MEM_VALID1
MEM_RDEN2  in  1  load request strobe
MEM_WE2  in  1  store request strobe
MEM_ADDR2  in  32  data byte address
MEM_DIN2  in  32  store data, right-justified
MEM_SIZE  in  2  00 byte, 01 half, 10 word, 11 illegal (funct3[1:0])
MEM_SIGN  in  1  1 = zero-extend load (funct3[2])
MEM_DOUT2  out  32  extended load data
MEM_VALID2  out  1  one-cycle data response pulse
MEM_ERR2  out  1  data fault, qualified by MEM_VALID2
IO_IN  in  32  MMIO read data
IO_ADDR  out  32  MMIO address
IO_OUT  out  32  MMIO write data
IO_WR  out  1  one-cycle MMIO write strobe

Behaviour:
- Reset (async, RST_N=0): both port FSMs go to IDLE. All outputs are 0. Array contents are not cleared. An in-flight store is dropped and never committed.
- Each port has its own FSM: IDLE -> WAIT -> RESP -> IDLE. A request is accepted only in IDLE; strobes seen in WAIT or RESP are ignored and are not queued.
- On acceptance the port registers address, size, sign and data, and loads a counter with WAIT_STATES.
- With WAIT_STATES=0, IDLE goes straight to RESP on the next edge, so the response comes one cycle after the request.
- In WAIT the counter decrements each cycle; the FSM moves to RESP on the edge where the count reaches 0. Total latency is WAIT_STATES+1 cycles.
- Array read and write both happen on the edge entering RESP. MEM_VALIDx is high for exactly the RESP cycle. DOUT holds its value until the next response.
- If MEM_RDEN2 and MEM_WE2 are both high, the store wins and no load is performed.
- Store byte lanes: byte uses DIN2[7:0] at lane addr[1:0]; half uses DIN2[15:0] at lane addr[1]*2; word writes all 4 lanes.
- Load extension: byte/half are sign-extended when MEM_SIGN=0 and zero-extended when MEM_SIGN=1.
- Misalignment faults: half with addr[0]=1, word with addr[1:0]!=0, or MEM_SIZE=11. Any of these gives ERR2=1 and DOUT2=0, and suppresses the write.
- Fetch faults: ERR1=1 and DOUT1=0 when addr[1:0]!=0 or addr >= MMIO_BASE.
- Addresses below MMIO_BASE index the array with addr[ADDR_WIDTH+1:2]; higher bits are ignored, so the array wraps.
- MMIO, port 2, addr >= MMIO_BASE:
  - Store: IO_WR is pulsed in the RESP cycle with IO_ADDR and IO_OUT, and the array is untouched.
  - Load: IO_IN is sampled on the edge entering RESP, then size/sign rules are applied.
  - IO_ADDR holds the last port-2 MMIO address.
- Simultaneous same-word events: a port-1 read and a port-2 write committing on the same edge means port 1 returns the old data (read-before-write).
- Ports 1 and 2 never block each other.

Optional Feature:
OTTER_MEM_PERF_EN:
- Defined: adds outputs PERF_RD_CNT[31:0] and PERF_WR_CNT[31:0], reset to 0. They increment on each accepted port-2 load or store (faulting accesses included) and saturate at 32'hFFFF_FFFF.
- Undefined: these ports and their counters do not exist. All other behaviour is identical.

Decomposition:
- Package otter_mem_pkg holds:
  - mem_size_t enum (BYTE, HALF, WORD, ILLEGAL)
  - port_state_t enum (IDLE, WAIT, RESP)
  - MMIO_BASE_DEFAULT constant
  - lane-mask and extension functions
- Sub-module otter_mem_port_fsm (counter plus state) is instantiated twice.
- Array, steering and MMIO decode stay in the top module.

Test Plan:
- WAIT_STATES=1. Store word 0xDEADBEEF at 0x100, then load word 0x100 -> VALID2 2 cycles after each strobe, DOUT2=0xDEADBEEF, ERR2=0.
- Load byte 0x103 with SIGN=0 -> 0xFFFFFFDE. With SIGN=1 -> 0x000000DE. Load half 0x102 with SIGN=0 -> 0xFFFFDEAD.
- Store half at 0x101 -> ERR2=1, DOUT2=0, and a later word load of 0x100 still returns 0xDEADBEEF. Fetch at 0x102 -> ERR1=1.
- Store 0x5A to 0x1100_0004 -> IO_WR single-cycle pulse, IO_ADDR=0x11000004, IO_OUT=0x5A. Load with IO_IN=0x80 and SIZE=byte, SIGN=0 -> DOUT2=0xFFFFFF80.
- Same-edge commit of a port-2 word store 0x12345678 to 0x200 and a port-1 fetch of 0x200 (old 0x0) -> DOUT1=0x0, and the next fetch returns 0x12345678.
- Assert MEM_WE2 (0x300, 0xAA), drop RST_N during WAIT -> all outputs 0 immediately, word at 0x300 unchanged. With PERF_EN, PERF_WR_CNT=0 after reset.
